// File: rtl/host_wireout_bridge.sv
// host_wireout_bridge
// Buffers a valid/ready DUT output stream in a small circular FIFO.
// Presents the head word to a host poll loop through FrontPanel wire-outs.
// The host consumes the head by flipping one wire-in toggle bit (host_ack_tog).
// Each flip pops at most one word, so the host sees every word exactly once.
//
// Optional feature macro: HOST_BRIDGE_ERR_EN
//   defined   -> adds the sticky host_err output, set by an ack while empty.
//   undefined -> no host_err port or register; such acks are silently ignored.
module host_wireout_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [WIDTH-1:0]         enq_bits,
  input  logic                     host_ack_tog,
  output logic                     host_valid,
  output logic [WIDTH-1:0]         host_bits,
  output logic                     host_seq,
  output logic [$clog2(DEPTH):0]   host_count
`ifdef HOST_BRIDGE_ERR_EN
  ,
  output logic                     host_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] EMPTY_CNT = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CNT   = CW'(1'b1);
  localparam logic [AW-1:0] ONE_PTR   = AW'(1'b1);

  // Storage and state registers
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  // The wire-in bit is first captured in ack_sync_q; ack_q holds the
  // previous capture.  A flip seen at edge M therefore becomes an edge in the
  // cycle ending at edge M+1, which is when the pop takes effect.
  logic             ack_sync_q, ack_sync_d;
  logic             ack_q,      ack_d;
  logic             seq_q,      seq_d;
`ifdef HOST_BRIDGE_ERR_EN
  logic             err_q,      err_d;
`endif

  // Decoded control
  logic push_s;
  logic pop_s;
  logic ack_edge_s;
  logic spurious_s;
  logic valid_s;
  logic ready_s;

  // Status derived from registered occupancy only (no same-cycle bypass)
  always_comb begin
    valid_s = (count_q != EMPTY_CNT);
    ready_s = (count_q != FULL_CNT);
  end

  // Handshake decode: accepted write, detected ack edge, pop, spurious ack
  always_comb begin
    push_s     = enq_valid & ready_s;
    ack_edge_s = ack_sync_q ^ ack_q;
    pop_s      = ack_edge_s & valid_s;
    spurious_s = ack_edge_s & ~valid_s;
  end

  // Next-state for pointers and occupancy
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Next-state for ack capture, sequence parity and error flag
  always_comb begin
    ack_sync_d = host_ack_tog;
    ack_d      = ack_sync_q;
    if (pop_s) begin
      seq_d = ~seq_q;
    end else begin
      seq_d = seq_q;
    end
  end

`ifdef HOST_BRIDGE_ERR_EN
  // Sticky error: set by any ack while nothing is presented
  always_comb begin
    if (spurious_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end
`endif

  // State registers; reset discards buffered words and aligns the ack
  // history with the current wire value so a stale toggle makes no edge
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q   <= {AW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      count_q    <= EMPTY_CNT;
      ack_sync_q <= host_ack_tog;
      ack_q      <= host_ack_tog;
      seq_q      <= host_ack_tog;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ack_sync_q <= ack_sync_d;
      ack_q      <= ack_d;
      seq_q      <= seq_d;
    end
  end

`ifdef HOST_BRIDGE_ERR_EN
  // Error flag register, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

  // FIFO storage write; contents are intentionally not reset
  always_ff @(posedge clock) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= enq_bits;
    end
  end

  // Output drive, all from registered state; empty head reads as zero
  always_comb begin
    enq_ready  = ready_s;
    host_valid = valid_s;
    host_seq   = seq_q;
    host_count = count_q;
    if (valid_s) begin
      host_bits = mem_q[rd_ptr_q];
    end else begin
      host_bits = {WIDTH{1'b0}};
    end
`ifdef HOST_BRIDGE_ERR_EN
    host_err = err_q;
`endif
  end

endmodule

// File: tb/tb_host_wireout_bridge.sv
// Self-checking bench for host_wireout_bridge: directed test-plan scenarios
// followed by randomized traffic, all checked every cycle against a queue
// model built from the bridge's externally visible rules.
module tb_host_wireout_bridge;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enq_valid = 1'b0;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits = '0;
  logic             host_ack_tog = 1'b1;
  logic             host_valid;
  logic [WIDTH-1:0] host_bits;
  logic             host_seq;
  logic [CW-1:0]    host_count;
`ifdef HOST_BRIDGE_ERR_EN
  logic             host_err;
`endif

  host_wireout_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_bits     (enq_bits),
    .host_ack_tog (host_ack_tog),
    .host_valid   (host_valid),
    .host_bits    (host_bits),
    .host_seq     (host_seq),
    .host_count   (host_count)
`ifdef HOST_BRIDGE_ERR_EN
    ,
    .host_err     (host_err)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of buffered words, consumed-parity, error flag,
  // and the wire values seen at the last two edges (a flip takes effect
  // one edge after it is first sampled).
  logic [WIDTH-1:0] mq[$];
  logic m_seq = 1'b0;
  logic m_err = 1'b0;
  logic seen1 = 1'b0;
  logic seen2 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance the model across one clock edge using the inputs now applied
  task automatic model_step();
    bit flip;
    bit had_word;
    bit room;
    if (reset) begin
      mq.delete();
      m_seq = host_ack_tog;
      m_err = 1'b0;
      seen1 = host_ack_tog;
      seen2 = host_ack_tog;
    end else begin
      flip     = (seen1 != seen2);
      had_word = (mq.size() > 0);
      room     = (mq.size() < DEPTH);
      if (flip && had_word) begin
        void'(mq.pop_front());
        m_seq = ~m_seq;
      end else if (flip) begin
        m_err = 1'b1;
      end
      if (enq_valid && room) mq.push_back(enq_bits);
      seen2 = seen1;
      seen1 = host_ack_tog;
    end
  endtask

  task automatic cmp_model();
    logic [WIDTH-1:0] head;
    head = (mq.size() > 0) ? mq[0] : '0;
    chk("m_valid", 32'(host_valid), 32'(mq.size() != 0));
    chk("m_bits",  32'(host_bits),  32'(head));
    chk("m_count", 32'(host_count), 32'(mq.size()));
    chk("m_ready", 32'(enq_ready),  32'(mq.size() != DEPTH));
    chk("m_seq",   32'(host_seq),   32'(m_seq));
`ifdef HOST_BRIDGE_ERR_EN
    chk("m_err",   32'(host_err),   32'(m_err));
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    cmp_model();
  endtask

  // Host poll step: read head, flip ack, wait for host_seq to follow
  task automatic host_pop(input logic [WIDTH-1:0] exp);
    chk("pop_valid", 32'(host_valid), 32'd1);
    chk("pop_bits",  32'(host_bits),  32'(exp));
    host_ack_tog = ~host_ack_tog;
    cycle();
    cycle();
    chk("seq_follow", 32'(host_seq), 32'(host_ack_tog));
  endtask

  initial begin
    logic s;

    // Reset with ack wire at 1
    reset = 1'b1; host_ack_tog = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("rst_seq",   32'(host_seq),   32'd1);
    chk("rst_valid", 32'(host_valid), 32'd0);
    chk("rst_bits",  32'(host_bits),  32'd0);
    chk("rst_ready", 32'(enq_ready),  32'd1);
    chk("rst_count", 32'(host_count), 32'd0);
    cycle(); cycle(); cycle();
    chk("hold_count", 32'(host_count), 32'd0);
    chk("hold_seq",   32'(host_seq),   32'd1);

    // Single word, then one flip
    enq_valid = 1'b1; enq_bits = 16'h1234;
    cycle();
    enq_valid = 1'b0;
    chk("one_valid", 32'(host_valid), 32'd1);
    chk("one_bits",  32'(host_bits),  32'h1234);
    host_ack_tog = ~host_ack_tog;
    cycle();
    cycle();
    chk("one_seq",   32'(host_seq),   32'(host_ack_tog));
    chk("one_empty", 32'(host_valid), 32'd0);
    chk("one_bits0", 32'(host_bits),  32'd0);

    // Fill to capacity; a further word is held off
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1'b1; enq_bits = 16'hA000 + 16'(i);
      cycle();
    end
    enq_bits = 16'hBEEF;
    cycle();
    chk("full_ready", 32'(enq_ready),  32'd0);
    chk("full_count", 32'(host_count), 32'd8);
    enq_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) host_pop(16'hA000 + 16'(i));

    // Full FIFO, one pop with a word waiting: no bypass into the pop cycle
    for (int i = 0; i < DEPTH; i++) begin
      enq_valid = 1'b1; enq_bits = 16'hB000 + 16'(i);
      cycle();
    end
    enq_bits = 16'hC000;
    host_ack_tog = ~host_ack_tog;
    cycle();
    chk("bp_count_m", 32'(host_count), 32'd8);
    cycle();
    chk("bp_count_pop", 32'(host_count), 32'd7);
    chk("bp_ready_pop", 32'(enq_ready),  32'd1);
    cycle();
    chk("bp_count_refill", 32'(host_count), 32'd8);
    enq_valid = 1'b0;
    for (int i = 1; i < DEPTH; i++) host_pop(16'hB000 + 16'(i));
    host_pop(16'hC000);

    // Ack while empty: no pop, sequence unchanged, error sticks
    s = host_seq;
    host_ack_tog = ~host_ack_tog;
    cycle(); cycle();
    chk("spur_seq", 32'(host_seq), 32'(s));
`ifdef HOST_BRIDGE_ERR_EN
    chk("spur_err", 32'(host_err), 32'd1);
`endif
    cycle(); cycle(); cycle();
`ifdef HOST_BRIDGE_ERR_EN
    chk("spur_err_sticky", 32'(host_err), 32'd1);
`endif

    // Ack edge on an empty FIFO in the same cycle as an enqueue
    host_ack_tog = ~host_ack_tog;
    cycle();
    enq_valid = 1'b1; enq_bits = 16'h5A5A;
    cycle();
    enq_valid = 1'b0;
    chk("same_valid", 32'(host_valid), 32'd1);
    chk("same_bits",  32'(host_bits),  32'h5A5A);
    chk("same_count", 32'(host_count), 32'd1);
    cycle();
    host_pop(16'h5A5A);

    // Reset mid-stream with five words buffered
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_bits = 16'hD000 + 16'(i);
      cycle();
    end
    enq_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mid_rst_count", 32'(host_count), 32'd0);
    chk("mid_rst_valid", 32'(host_valid), 32'd0);
`ifdef HOST_BRIDGE_ERR_EN
    chk("mid_rst_err", 32'(host_err), 32'd0);
`endif
    enq_valid = 1'b1; enq_bits = 16'h00FF;
    cycle();
    enq_valid = 1'b0;
    chk("mid_new_bits",  32'(host_bits),  32'h00FF);
    chk("mid_new_count", 32'(host_count), 32'd1);
    host_pop(16'h00FF);

    // Randomized traffic, arbitrary ack timing and occasional resets
    for (int i = 0; i < 3000; i++) begin
      enq_valid = 1'($urandom_range(0, 1));
      enq_bits  = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) host_ack_tog = ~host_ack_tog;
      reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0; enq_valid = 1'b0;
    cycle(); cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
